// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types for the interconnect: field widths, response codes,
// channel bundles and the arbiter state encoding.
package axi_lite_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 8;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int MAX_MST    = 4;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [STRB_WIDTH-1:0] strb_t;
    typedef logic [1:0]            resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RADDR,
        RDATA,
        WADDR,
        WDATA,
        WRESP
    } state_type;

    typedef struct packed {
        addr_t ar_addr;
        logic  ar_valid;
        logic  r_ready;
        addr_t aw_addr;
        logic  aw_valid;
        data_t w_data;
        strb_t w_strb;
        logic  w_valid;
        logic  b_ready;
    } axi_lite_req_t;

    typedef struct packed {
        logic  ar_ready;
        data_t r_data;
        resp_t r_resp;
        logic  r_valid;
        logic  aw_ready;
        logic  w_ready;
        resp_t b_resp;
        logic  b_valid;
    } axi_lite_rsp_t;

endpackage

// File: rtl/axi_lite_rr_pick.sv
// Round-robin winner selection: first requester at or after rr_ptr, wrapping.
module axi_lite_rr_pick
    import axi_lite_pkg::*;
#(
    parameter int NUM_MST = 2,
    parameter int IDX_W   = $clog2(NUM_MST)
) (
    input  logic [NUM_MST-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_MST-1:0] winner,
    output logic [IDX_W-1:0]   win_idx
);

    logic found;

    // Outer loop walks priority order from rr_ptr; inner loop keeps every index constant.
    always_comb begin
        winner  = '0;
        win_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_MST; k++) begin
            for (int j = 0; j < NUM_MST; j++) begin
                if (!found && req[j] && (j == ((int'(rr_ptr) + k) % NUM_MST))) begin
                    found     = 1'b1;
                    winner[j] = 1'b1;
                    win_idx   = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/axi_lite_rr_arbiter.sv
// N-master to 1-slave AXI4-Lite arbiter: round-robin grant, one transaction in
// flight, granted master's channels forwarded combinationally.
module axi_lite_rr_arbiter
    import axi_lite_pkg::*;
#(
    parameter int NUM_MST = 2
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  axi_lite_req_t [NUM_MST-1:0]  mst_req,
    output axi_lite_rsp_t [NUM_MST-1:0]  mst_rsp,
    output axi_lite_req_t                slv_req,
    input  axi_lite_rsp_t                slv_rsp,
    output logic [NUM_MST-1:0]           grant,
    output logic                         busy
);

    localparam int IDX_W = $clog2(NUM_MST);

    state_type          state, state_nxt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   gnt_idx;
    logic [NUM_MST-1:0] grant_q;
    logic [NUM_MST-1:0] req_vec;
    logic [NUM_MST-1:0] winner;
    logic [IDX_W-1:0]   win_idx;
    logic               txn_done;
    axi_lite_req_t      sel_req;

    always_comb begin
        for (int i = 0; i < NUM_MST; i++) begin
            req_vec[i] = mst_req[i].ar_valid | mst_req[i].aw_valid;
        end
    end

    axi_lite_rr_pick #(
        .NUM_MST (NUM_MST),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req     (req_vec),
        .rr_ptr  (rr_ptr),
        .winner  (winner),
        .win_idx (win_idx)
    );

    assign sel_req = mst_req[gnt_idx];

    // Only the channel owned by the current state is routed; everything else stays 0.
    always_comb begin
        state_nxt = state;
        txn_done  = 1'b0;
        slv_req   = '0;
        mst_rsp   = '0;
        case (state)
            IDLE: begin
                if (|req_vec) begin
                    state_nxt = mst_req[win_idx].ar_valid ? RADDR : WADDR;
                end
            end
            RADDR: begin
                slv_req.ar_addr           = sel_req.ar_addr;
                slv_req.ar_valid          = sel_req.ar_valid;
                mst_rsp[gnt_idx].ar_ready = slv_rsp.ar_ready;
                if (sel_req.ar_valid && slv_rsp.ar_ready) begin
                    state_nxt = RDATA;
                end
            end
            RDATA: begin
                mst_rsp[gnt_idx].r_data  = slv_rsp.r_data;
                mst_rsp[gnt_idx].r_resp  = slv_rsp.r_resp;
                mst_rsp[gnt_idx].r_valid = slv_rsp.r_valid;
                slv_req.r_ready          = sel_req.r_ready;
                if (slv_rsp.r_valid && sel_req.r_ready) begin
                    state_nxt = IDLE;
                    txn_done  = 1'b1;
                end
            end
            WADDR: begin
                slv_req.aw_addr           = sel_req.aw_addr;
                slv_req.aw_valid          = sel_req.aw_valid;
                mst_rsp[gnt_idx].aw_ready = slv_rsp.aw_ready;
                if (sel_req.aw_valid && slv_rsp.aw_ready) begin
                    state_nxt = WDATA;
                end
            end
            WDATA: begin
                slv_req.w_data           = sel_req.w_data;
                slv_req.w_strb           = sel_req.w_strb;
                slv_req.w_valid          = sel_req.w_valid;
                mst_rsp[gnt_idx].w_ready = slv_rsp.w_ready;
                if (sel_req.w_valid && slv_rsp.w_ready) begin
                    state_nxt = WRESP;
                end
            end
            WRESP: begin
                mst_rsp[gnt_idx].b_resp  = slv_rsp.b_resp;
                mst_rsp[gnt_idx].b_valid = slv_rsp.b_valid;
                slv_req.b_ready          = sel_req.b_ready;
                if (slv_rsp.b_valid && sel_req.b_ready) begin
                    state_nxt = IDLE;
                    txn_done  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            gnt_idx <= '0;
            grant_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && |req_vec) begin
                grant_q <= winner;
                gnt_idx <= win_idx;
            end else if (txn_done) begin
                grant_q <= '0;
                rr_ptr  <= (gnt_idx == IDX_W'(NUM_MST - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    assign grant = grant_q;
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
// Bench for axi_lite_rr_arbiter: transaction-level reference model checked every
// cycle, a reactive slave, and directed master scenarios with literal expectations.
module tb_axi_lite_rr_arbiter;
    import axi_lite_pkg::*;

    localparam int N = 2;

    logic                  aclk = 1'b0;
    logic                  areset = 1'b1;
    axi_lite_req_t [N-1:0] mst_req = '0;
    axi_lite_rsp_t [N-1:0] mst_rsp;
    axi_lite_req_t         slv_req;
    axi_lite_rsp_t         slv_rsp = '0;
    logic [N-1:0]          grant;
    logic                  busy;

    int vectors = 0;
    int miscompares = 0;

    axi_lite_rr_arbiter #(.NUM_MST(N)) dut (
        .aclk    (aclk),
        .areset  (areset),
        .mst_req (mst_req),
        .mst_rsp (mst_rsp),
        .slv_req (slv_req),
        .slv_rsp (slv_rsp),
        .grant   (grant),
        .busy    (busy)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tmo(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: timeout waiting for handshake at %0t", nm, $time);
    endtask

    // Reference model: owner of the slave (-1 when free), phase of its transaction, next-priority master.
    int mdl_owner = -1;
    int mdl_phase = 0;   // 0 free, 1 read addr, 2 read data, 3 write addr, 4 write data, 5 write resp
    int mdl_ptr = 0;
    int mdl_m;
    bit mdl_done;

    always @(posedge aclk or posedge areset) begin
        if (areset) begin
            mdl_owner = -1;
            mdl_phase = 0;
            mdl_ptr   = 0;
        end else if (mdl_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                mdl_m = (mdl_ptr + k) % N;
                if (mdl_owner < 0 && (mst_req[mdl_m].ar_valid || mst_req[mdl_m].aw_valid)) begin
                    mdl_owner = mdl_m;
                    mdl_phase = mst_req[mdl_m].ar_valid ? 1 : 3;
                end
            end
        end else begin
            mdl_done = 1'b0;
            case (mdl_phase)
                1: if (mst_req[mdl_owner].ar_valid && slv_rsp.ar_ready) mdl_phase = 2;
                2: if (slv_rsp.r_valid && mst_req[mdl_owner].r_ready) mdl_done = 1'b1;
                3: if (mst_req[mdl_owner].aw_valid && slv_rsp.aw_ready) mdl_phase = 4;
                4: if (mst_req[mdl_owner].w_valid && slv_rsp.w_ready) mdl_phase = 5;
                5: if (slv_rsp.b_valid && mst_req[mdl_owner].b_ready) mdl_done = 1'b1;
                default: mdl_done = 1'b0;
            endcase
            if (mdl_done) begin
                mdl_ptr   = (mdl_owner + 1) % N;
                mdl_owner = -1;
                mdl_phase = 0;
            end
        end
    end

    axi_lite_req_t         exp_slv;
    axi_lite_rsp_t [N-1:0] exp_mst;
    logic [N-1:0]          exp_grant;

    always @(negedge aclk) begin
        exp_slv   = '0;
        exp_mst   = '0;
        exp_grant = '0;
        if (mdl_owner >= 0) begin
            exp_grant[mdl_owner] = 1'b1;
            case (mdl_phase)
                1: begin
                    exp_slv.ar_addr            = mst_req[mdl_owner].ar_addr;
                    exp_slv.ar_valid           = mst_req[mdl_owner].ar_valid;
                    exp_mst[mdl_owner].ar_ready = slv_rsp.ar_ready;
                end
                2: begin
                    exp_mst[mdl_owner].r_data  = slv_rsp.r_data;
                    exp_mst[mdl_owner].r_resp  = slv_rsp.r_resp;
                    exp_mst[mdl_owner].r_valid = slv_rsp.r_valid;
                    exp_slv.r_ready            = mst_req[mdl_owner].r_ready;
                end
                3: begin
                    exp_slv.aw_addr             = mst_req[mdl_owner].aw_addr;
                    exp_slv.aw_valid            = mst_req[mdl_owner].aw_valid;
                    exp_mst[mdl_owner].aw_ready = slv_rsp.aw_ready;
                end
                4: begin
                    exp_slv.w_data             = mst_req[mdl_owner].w_data;
                    exp_slv.w_strb             = mst_req[mdl_owner].w_strb;
                    exp_slv.w_valid            = mst_req[mdl_owner].w_valid;
                    exp_mst[mdl_owner].w_ready = slv_rsp.w_ready;
                end
                5: begin
                    exp_mst[mdl_owner].b_resp  = slv_rsp.b_resp;
                    exp_mst[mdl_owner].b_valid = slv_rsp.b_valid;
                    exp_slv.b_ready            = mst_req[mdl_owner].b_ready;
                end
                default: exp_slv = '0;
            endcase
        end
        chk("cyc_grant", 128'(grant), 128'(exp_grant));
        chk("cyc_busy", 128'(busy), 128'(mdl_owner >= 0));
        chk("cyc_slv_req", 128'(slv_req), 128'(exp_slv));
        chk("cyc_mst_rsp", 128'(mst_rsp), 128'(exp_mst));
    end

    // Grant log: one entry per transaction, the index granted.
    int          glog[$];
    logic [N-1:0] prev_grant = '0;
    always @(negedge aclk) begin
        if (grant != '0 && prev_grant == '0) begin
            for (int i = 0; i < N; i++) if (grant[i]) glog.push_back(i);
        end
        prev_grant = grant;
    end

    // Reactive slave: read data = 0xA1 + addr[7:0]; addr >= 0x40 answers DECERR.
    int    aw_stall = 0;
    bit    w_hold = 1'b0;
    int    aw_cnt = 0;
    addr_t ar_log[$];
    addr_t aw_log[$];
    data_t wd_log[$];
    strb_t ws_log[$];
    time   t_ar = 0, t_aw = 0;
    bit    s_ar, s_r, s_aw, s_awv, s_w, s_b;
    addr_t s_ar_a, s_aw_a;
    data_t s_wd;
    strb_t s_ws;

    initial begin
        forever begin
            @(negedge aclk);
            s_ar   = slv_req.ar_valid && slv_rsp.ar_ready;
            s_ar_a = slv_req.ar_addr;
            s_r    = slv_req.r_ready && slv_rsp.r_valid;
            s_aw   = slv_req.aw_valid && slv_rsp.aw_ready;
            s_awv  = slv_req.aw_valid;
            s_aw_a = slv_req.aw_addr;
            s_w    = slv_req.w_valid && slv_rsp.w_ready;
            s_wd   = slv_req.w_data;
            s_ws   = slv_req.w_strb;
            s_b    = slv_req.b_ready && slv_rsp.b_valid;
            @(posedge aclk);
            #1;
            if (areset) begin
                slv_rsp          = '0;
                slv_rsp.ar_ready = 1'b1;
                aw_cnt           = 0;
            end else begin
                if (s_ar) begin
                    ar_log.push_back(s_ar_a);
                    t_ar             = $time;
                    slv_rsp.ar_ready = 1'b0;
                    slv_rsp.r_valid  = 1'b1;
                    slv_rsp.r_data   = 8'hA1 + s_ar_a[7:0];
                    slv_rsp.r_resp   = (s_ar_a >= 32'h40) ? RESP_DECERR : RESP_OKAY;
                end
                if (s_r) begin
                    slv_rsp.r_valid  = 1'b0;
                    slv_rsp.ar_ready = 1'b1;
                end
                if (s_aw) begin
                    aw_log.push_back(s_aw_a);
                    t_aw             = $time;
                    slv_rsp.aw_ready = 1'b0;
                    aw_cnt           = 0;
                end else if (s_awv) begin
                    aw_cnt++;
                    slv_rsp.aw_ready = (aw_cnt >= aw_stall);
                end
                if (s_w) begin
                    wd_log.push_back(s_wd);
                    ws_log.push_back(s_ws);
                    slv_rsp.b_valid = 1'b1;
                    slv_rsp.b_resp  = RESP_OKAY;
                end
                if (s_b) slv_rsp.b_valid = 1'b0;
                slv_rsp.w_ready = !w_hold;
            end
        end
    end

    task automatic do_reset();
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        @(posedge aclk);
        #1;
    endtask

    task automatic mst_read(input int m, input addr_t a, output data_t d, output resp_t r);
        int n;
        bit got;
        d = '0;
        r = '0;
        mst_req[m].ar_addr  = a;
        mst_req[m].ar_valid = 1'b1;
        mst_req[m].r_ready  = 1'b1;
        n = 0; got = 0;
        while (!got && n < 200) begin
            @(negedge aclk);
            got = mst_rsp[m].ar_ready;
            n++;
            @(posedge aclk);
            #1;
        end
        mst_req[m].ar_valid = 1'b0;
        if (!got) tmo("ar_handshake");
        n = 0; got = 0;
        while (!got && n < 200) begin
            @(negedge aclk);
            if (mst_rsp[m].r_valid) begin
                got = 1;
                d   = mst_rsp[m].r_data;
                r   = mst_rsp[m].r_resp;
            end
            n++;
            @(posedge aclk);
            #1;
        end
        mst_req[m].r_ready = 1'b0;
        if (!got) tmo("r_handshake");
    endtask

    task automatic mst_write(input int m, input addr_t a, input data_t d, input strb_t s, output resp_t r);
        int n;
        bit got;
        r = '0;
        mst_req[m].aw_addr  = a;
        mst_req[m].aw_valid = 1'b1;
        mst_req[m].w_data   = d;
        mst_req[m].w_strb   = s;
        mst_req[m].w_valid  = 1'b1;
        mst_req[m].b_ready  = 1'b1;
        n = 0; got = 0;
        while (!got && n < 200) begin
            @(negedge aclk);
            got = mst_rsp[m].aw_ready;
            n++;
            @(posedge aclk);
            #1;
        end
        mst_req[m].aw_valid = 1'b0;
        if (!got) tmo("aw_handshake");
        n = 0; got = 0;
        while (!got && n < 200) begin
            @(negedge aclk);
            got = mst_rsp[m].w_ready;
            n++;
            @(posedge aclk);
            #1;
        end
        mst_req[m].w_valid = 1'b0;
        if (!got) tmo("w_handshake");
        n = 0; got = 0;
        while (!got && n < 200) begin
            @(negedge aclk);
            if (mst_rsp[m].b_valid) begin
                got = 1;
                r   = mst_rsp[m].b_resp;
            end
            n++;
            @(posedge aclk);
            #1;
        end
        mst_req[m].b_ready = 1'b0;
        if (!got) tmo("b_handshake");
    endtask

    data_t d0, d1, d2;
    resp_t r0, r1, r2;
    int    n;
    bit    seen;

    initial begin
        do_reset();
        chk("rst_grant", 128'(grant), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_slv_req", 128'(slv_req), 128'(0));
        chk("rst_mst_rsp", 128'(mst_rsp), 128'(0));

        // 1) single read by M0
        glog.delete();
        mst_read(0, 32'h4, d0, r0);
        chk("t1_rdata", 128'(d0), 128'(8'hA5));
        chk("t1_rresp", 128'(r0), 128'(2'b00));
        chk("t1_glog_len", 128'(glog.size()), 128'(1));
        if (glog.size() > 0) chk("t1_glog0", 128'(glog[0]), 128'(0));

        // 2) simultaneous reads from reset, then again to show rotation restarted at M0
        do_reset();
        glog.delete();
        ar_log.delete();
        fork
            mst_read(0, 32'h8, d0, r0);
            mst_read(1, 32'hC, d1, r1);
        join
        chk("t2_m0_data", 128'(d0), 128'(8'hA9));
        chk("t2_m1_data", 128'(d1), 128'(8'hAD));
        chk("t2_ar_len", 128'(ar_log.size()), 128'(2));
        if (ar_log.size() == 2) begin
            chk("t2_ar_first", 128'(ar_log[0]), 128'(32'h8));
            chk("t2_ar_second", 128'(ar_log[1]), 128'(32'hC));
        end
        fork
            mst_read(0, 32'h0, d0, r0);
            mst_read(1, 32'h1, d1, r1);
        join
        chk("t2_glog_len", 128'(glog.size()), 128'(4));
        if (glog.size() == 4) begin
            chk("t2_g0", 128'(glog[0]), 128'(0));
            chk("t2_g1", 128'(glog[1]), 128'(1));
            chk("t2_g2", 128'(glog[2]), 128'(0));
            chk("t2_g3", 128'(glog[3]), 128'(1));
        end

        // 3) M1 write with a slow aw_ready
        aw_log.delete();
        wd_log.delete();
        ws_log.delete();
        aw_stall = 3;
        mst_write(1, 32'h14, 8'h3C, 1'b1, r1);
        aw_stall = 0;
        chk("t3_bresp", 128'(r1), 128'(RESP_OKAY));
        chk("t3_aw_len", 128'(aw_log.size()), 128'(1));
        if (aw_log.size() == 1) chk("t3_aw_addr", 128'(aw_log[0]), 128'(32'h14));
        if (wd_log.size() == 1) begin
            chk("t3_wdata", 128'(wd_log[0]), 128'(8'h3C));
            chk("t3_wstrb", 128'(ws_log[0]), 128'(1));
        end else tmo("t3_w_count");

        // 4) M0 read and write together: read first
        glog.delete();
        fork
            mst_read(0, 32'h10, d0, r0);
            mst_write(0, 32'h18, 8'h55, 1'b1, r2);
        join
        chk("t4_rdata", 128'(d0), 128'(8'hB1));
        chk("t4_bresp", 128'(r2), 128'(RESP_OKAY));
        chk("t4_ar_before_aw", 128'(t_ar < t_aw), 128'(1));
        chk("t4_glog_len", 128'(glog.size()), 128'(2));

        // 5) reset pulsed while the write data phase is stalled
        w_hold = 1'b1;
        mst_req[0].aw_addr  = 32'h20;
        mst_req[0].aw_valid = 1'b1;
        mst_req[0].w_data   = 8'h77;
        mst_req[0].w_strb   = 1'b1;
        mst_req[0].w_valid  = 1'b1;
        mst_req[0].b_ready  = 1'b1;
        n = 0; seen = 0;
        while (!seen && n < 50) begin
            @(negedge aclk);
            seen = slv_req.w_valid;
            n++;
        end
        if (!seen) tmo("t5_reach_wdata");
        #2;
        areset = 1'b1;
        #1;
        chk("t5_busy", 128'(busy), 128'(0));
        chk("t5_grant", 128'(grant), 128'(0));
        chk("t5_slv_req", 128'(slv_req), 128'(0));
        chk("t5_mst_rsp", 128'(mst_rsp), 128'(0));
        mst_req = '0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        w_hold = 1'b0;
        @(posedge aclk);
        #1;
        mst_read(1, 32'h8, d1, r1);
        chk("t5_m1_data", 128'(d1), 128'(8'hA9));
        chk("t5_m1_resp", 128'(r1), 128'(RESP_OKAY));

        // 6) M0 streams reads, M1 asks once and gets DECERR
        glog.delete();
        fork
            begin
                repeat (3) begin
                    mst_read(0, 32'h4, d0, r0);
                    chk("t6_m0_data", 128'(d0), 128'(8'hA5));
                end
            end
            begin
                @(posedge aclk);
                #1;
                mst_read(1, 32'h40, d1, r1);
            end
        join
        chk("t6_m1_resp", 128'(r1), 128'(RESP_DECERR));
        chk("t6_m1_data", 128'(d1), 128'(8'hE1));
        chk("t6_glog_len", 128'(glog.size()), 128'(4));
        if (glog.size() == 4) begin
            chk("t6_g0", 128'(glog[0]), 128'(0));
            chk("t6_g1", 128'(glog[1]), 128'(1));
            chk("t6_g2", 128'(glog[2]), 128'(0));
            chk("t6_g3", 128'(glog[3]), 128'(0));
        end

        repeat (3) @(posedge aclk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
